// File: rtl/mc_alu.sv
// mc_alu: multi-cycle integer ALU with a valid/ready handshake on both sides.
//   Single-cycle ops: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU.
//   Iterative ops (XLEN BUSY cycles): MUL MULHU (shift-add) and DIVU REMU (restoring).
//   Opcodes 14-15 complete through DONE with result=0 and illegal=1.
// Ports:
//   clk, rst       - rising-edge clock, asynchronous active-high reset
//   in_valid       - request present; accepted when in_ready is also high
//   in_ready       - high only in IDLE
//   alu_op, a, b   - operation and operands, captured on accept
//   out_valid      - result/illegal valid; high only in DONE
//   out_ready      - consumer takes the result; DONE returns to IDLE
//   result         - registered result, held stable throughout DONE
//   illegal        - registered, set when the accepted op was unknown
module mc_alu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13
  } op_t;

  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(XLEN-1);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  state_t state, state_nx;

  logic [3:0]        op_q;
  logic [XLEN-1:0]   opnd_q;    // multiplicand for MUL*, divisor for DIV*/REM*
  logic [2*XLEN-1:0] prod_q;    // {hi, lo}: product, or {remainder, quotient}
  logic [SHW:0]      cnt_q;

  logic              accept;
  logic              is_multi;
  logic              last_iter;
  logic [SHW-1:0]    sh;
  logic [XLEN-1:0]   sc_result;
  logic              sc_illegal;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_nx;
  logic              op_is_mul;

  assign accept    = in_valid && (state == S_IDLE);
  assign is_multi  = alu_op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
  assign last_iter = (state == S_BUSY) && (cnt_q == CNT_LAST);
  assign sh        = b[SHW-1:0];
  assign op_is_mul = (op_q == OP_MUL) || (op_q == OP_MULHU);

  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
    case (alu_op)
      OP_ADD:  sc_result = a + b;
      OP_SUB:  sc_result = a - b;
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_XOR:  sc_result = a ^ b;
      OP_SLL:  sc_result = a << sh;
      OP_SRL:  sc_result = a >> sh;
      OP_SRA:  sc_result = XLEN'($signed(a) >>> sh);
      OP_SLT:  sc_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_result = {{(XLEN-1){1'b0}}, (a < b)};
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: sc_result = '0;
      default: sc_illegal = 1'b1;
    endcase
  end

  // One iteration step. Multiply adds the multiplicand into the high half when
  // the current LSB is set, then shifts the whole register right (carry enters
  // at the top). Divide shifts the next dividend bit into the remainder and
  // subtracts the divisor when it fits; a zero divisor always "fits", which
  // naturally yields all-ones quotient and remainder = dividend.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    if (op_is_mul) begin
      prod_nx = {mul_sum, prod_q[XLEN-1:1]};
    end else begin
      prod_nx = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                 prod_q[XLEN-2:0], div_ge};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = is_multi ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        if (cnt_q == CNT_LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      opnd_q  <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      result  <= '0;
      illegal <= 1'b0;
    end else if (accept) begin
      op_q  <= alu_op;
      cnt_q <= '0;
      if (is_multi) begin
        illegal <= 1'b0;
        if ((alu_op == OP_MUL) || (alu_op == OP_MULHU)) begin
          opnd_q <= a;
          prod_q <= {{XLEN{1'b0}}, b};
        end else begin
          opnd_q <= b;
          prod_q <= {{XLEN{1'b0}}, a};
        end
      end else begin
        result  <= sc_result;
        illegal <= sc_illegal;
      end
    end else if (state == S_BUSY) begin
      prod_q <= prod_nx;
      cnt_q  <= cnt_q + CNT_ONE;
      if (last_iter) begin
        // Low half holds MUL product / DIVU quotient; high half MULHU / REMU.
        if ((op_q == OP_MUL) || (op_q == OP_DIVU)) result <= prod_nx[XLEN-1:0];
        else                                       result <= prod_nx[2*XLEN-1:XLEN];
      end
    end
  end

endmodule

// File: doc/mc_alu.md
# mc_alu

Parametrised multi-cycle ALU for the minirv core, succeeding the single-op combinational adder. Executes the full RV32I integer op set in one cycle plus unsigned multiply/divide/remainder iteratively, behind a valid/ready handshake on both sides so the execute stage can stall on long ops. Unknown opcodes raise a registered `illegal` flag instead of aborting simulation.

## Interface
- `XLEN`, 32: operand/result width; power of two, ≥ 8.
- `SHW`, $clog2(XLEN): shift-amount width, taken from `b[SHW-1:0]`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: request present.
- `in_ready` output 1: block can accept; high only in IDLE.
- `alu_op` input 4: operation, sampled on accept.
- `a`, `b` input XLEN: operands, sampled on accept.
- `out_valid` output 1: `result`/`illegal` valid; high only in DONE.
- `out_ready` input 1: consumer takes result.
- `result` output XLEN: registered result.
- `illegal` output 1: registered; 1 if the accepted op was unknown.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 0/1), 9 SLTU, 10 MUL (low XLEN bits), 11 MULHU (high XLEN bits, unsigned), 12 DIVU, 13 REMU; 14–15 illegal.
- All arithmetic wraps modulo 2^XLEN; shifts use `b[SHW-1:0]` only.
- FSM states:
  - IDLE: `in_ready`=1. On accept: ops 0–9 and 14–15 → DONE; ops 10–13 → BUSY.
  - BUSY: one iteration per cycle for XLEN cycles → DONE.
  - DONE: `out_valid`=1. On `out_ready` → IDLE.
- Operands, op and iteration state are captured on accept; input changes afterwards have no effect.
- Single-cycle ops: result computed from the inputs on the accept edge and registered into `result`.
- MUL/MULHU: shift-add over a 2·XLEN product register, one multiplier bit per cycle, LSB first.
- DIVU/REMU: restoring division, one quotient bit per cycle, MSB first.
- Divide by zero (b=0): DIVU → all ones; REMU → a. Still takes the full XLEN BUSY cycles.
- Illegal op: `result`=0, `illegal`=1, presented through DONE like any other op. `illegal` is 0 for legal ops.
- `result` and `illegal` hold stable throughout DONE, including while `out_ready` is low.

## Timing
- Reset (async assert, any state): state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `illegal`=0, iteration counter 0. Any in-flight op is discarded.
- Single-cycle op accepted at edge N: `out_valid` is high after edge N.
- Multi-cycle op accepted at edge N: BUSY occupies edges N+1..N+XLEN; `out_valid` is high after edge N+XLEN.
- Handshake:
  - A transfer occurs on an edge where valid and ready are both high.
  - No accept in BUSY or DONE.
  - `out_ready` high in DONE returns to IDLE on that edge.
  - The next accept happens no earlier than the following edge, so peak throughput is one op per 2 cycles.
- `out_ready` has no effect outside DONE; `in_valid` has no effect outside IDLE.
- Iteration counter width SHW+1; it terminates exactly at XLEN, with no off-by-one in MULHU's top bit or REMU's final subtract.

## Test plan
- Reset mid-op: assert `rst` during BUSY of DIVU 100/7 → outputs 0, `in_ready`=1 immediately; after release, ADD 1+2 → 3.
- Single-cycle sweep, XLEN=32, held `out_ready`=1:
  - SUB 0−1 → 0xFFFFFFFF.
  - SRA 0x80000000>>4 → 0xF8000000.
  - SLL 1<<33 → 2 (shift amount masked).
  - SLT −1<0 → 1; SLTU 0xFFFFFFFF<0 → 0.
  - Each with `out_valid` exactly 1 cycle after accept.
- Multiply: MUL and MULHU of 0xFFFFFFFF×0xFFFFFFFF → 0x00000001 and 0xFFFFFFFE; `out_valid` rises exactly 33 cycles after accept.
- Divide:
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - DIVU x/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234.
  - Latency 33 cycles for each.
- Backpressure: `out_ready`=0 for 5 cycles in DONE → `result` stable, `in_ready`=0, new `in_valid` ignored; release → IDLE next edge.
- Illegal and width: op 15 → `illegal`=1, `result`=0, and a following legal op clears `illegal`; repeat MUL/DIVU checks at XLEN=8 (DIVU 200/3 → 66 after 9 cycles).
